serial_fb_writer: RTL and testbench

- Consumes the byte stream from the UART receiver, i.e. the 8-bit byte plus its one-cycle ready strobe.
- Parses fixed-format write packets and issues 16-bit word write requests to the SDRAM framebuffer arbiter over a req/ack handshake.
- Sits between the serial receiver and the SDRAM write port, so a host PC can load pixels into the VGA framebuffer.

---
 rtl/serial_fb_writer_if.sv | 13 +
 rtl/serial_fb_writer.sv | 206 ++++++++++++++++++++
 tb/tb_serial_fb_writer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_fb_writer_if.sv
// Word-write port between the serial packet parser and the SDRAM framebuffer arbiter.
// Request side is the master; the arbiter answers with a one-cycle ack.
interface serial_fb_writer_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;
    logic                  wr_ack;

    modport master (output wr_req, wr_addr, wr_data, input wr_ack);
    modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/serial_fb_writer.sv
// Turns UART write packets (CMD, A2, A1, A0, LEN, {DHI, DLO} x LEN+1) into framebuffer word writes.
// Defining SERIAL_FB_FILL_EN adds the fill command CMD_WRITE+1 (one data word repeated LEN+1 times).
module serial_fb_writer #(
    parameter int          ADDR_WIDTH = 22,
    parameter int          TIMEOUT    = 2000000,
    parameter logic [7:0]  CMD_WRITE  = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_byte,
    input  logic               rbyte_ready,
    serial_fb_writer_if.master wr,
    output logic               busy,
    output logic               frame_done,
    output logic               err_timeout,
    output logic               err_overflow
);
    localparam int                    TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]         TMO_ONE  = TW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, ADDR2, ADDR1, ADDR0, LEN, DHI, DLO, WAIT_ACK} state_t;

    state_t                state_q, state_d;
    logic [7:0]            hold_byte_q, hold_byte_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            hi_q, hi_d;
    logic                  wr_req_q, wr_req_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_overflow_q, err_overflow_d;
`ifdef SERIAL_FB_FILL_EN
    logic                  fill_q, fill_d;
`endif

    logic counting, consume, expire, acked;

    // The timeout only runs while a packet is waiting on the UART, never while stalled on the arbiter.
    assign counting = (state_q != IDLE) && (state_q != WAIT_ACK);
    assign consume  = hold_valid_q && (state_q != WAIT_ACK);
    assign expire   = counting && !hold_valid_q && (tmo_q == TMO_LAST);
    assign acked    = (state_q == WAIT_ACK) && wr_req_q && wr.wr_ack;

    always_comb begin
        state_d        = state_q;
        hold_byte_d    = hold_byte_q;
        hold_valid_d   = hold_valid_q;
        tmo_d          = tmo_q;
        addr_d         = addr_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        cnt_d          = cnt_q;
        hi_d           = hi_q;
        wr_req_d       = wr_req_q;
        frame_done_d   = 1'b0;
        err_timeout_d  = 1'b0;
        err_overflow_d = err_overflow_q;
`ifdef SERIAL_FB_FILL_EN
        fill_d         = fill_q;
`endif

        // A byte arriving while the holding slot stays occupied is lost.
        if (consume) begin
            hold_valid_d = 1'b0;
        end
        if (expire) begin
            hold_valid_d = 1'b0;
        end else if (rbyte_ready) begin
            if (hold_valid_q && !consume) begin
                err_overflow_d = 1'b1;
            end else begin
                hold_byte_d  = rx_byte;
                hold_valid_d = 1'b1;
            end
        end

        if (consume || expire) begin
            tmo_d = '0;
        end else if (counting) begin
            tmo_d = tmo_q + TMO_ONE;
        end

        case (state_q)
            IDLE: begin
                if (consume) begin
                    if (hold_byte_q == CMD_WRITE) begin
                        state_d = ADDR2;
                        addr_d  = '0;
`ifdef SERIAL_FB_FILL_EN
                        fill_d  = 1'b0;
                    end else if (hold_byte_q == CMD_WRITE + 8'd1) begin
                        state_d = ADDR2;
                        addr_d  = '0;
                        fill_d  = 1'b1;
`endif
                    end
                end
            end
            ADDR2, ADDR1, ADDR0: begin
                if (consume) begin
                    addr_d  = ADDR_WIDTH'({addr_q, hold_byte_q});
                    state_d = (state_q == ADDR2) ? ADDR1 : (state_q == ADDR1) ? ADDR0 : LEN;
                end
            end
            LEN: begin
                if (consume) begin
                    cnt_d   = hold_byte_q;
                    state_d = DHI;
                end
            end
            DHI: begin
                if (consume) begin
                    hi_d    = hold_byte_q;
                    state_d = DLO;
                end
            end
            DLO: begin
                if (consume) begin
                    wr_data_d = {hi_q, hold_byte_q};
                    wr_addr_d = addr_q;
                    wr_req_d  = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (acked) begin
                    wr_req_d = 1'b0;
                    addr_d   = addr_q + ADDR_ONE;
                    if (cnt_q == 8'd0) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = DHI;
`ifdef SERIAL_FB_FILL_EN
                        // Fill reuses the latched word and immediately requests the next address.
                        if (fill_q) begin
                            state_d   = WAIT_ACK;
                            wr_req_d  = 1'b1;
                            wr_addr_d = addr_q + ADDR_ONE;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (expire) begin
            state_d       = IDLE;
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            hold_byte_q    <= 8'h00;
            hold_valid_q   <= 1'b0;
            tmo_q          <= '0;
            addr_q         <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= 16'h0000;
            cnt_q          <= 8'h00;
            hi_q           <= 8'h00;
            wr_req_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
`ifdef SERIAL_FB_FILL_EN
            fill_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hold_byte_q    <= hold_byte_d;
            hold_valid_q   <= hold_valid_d;
            tmo_q          <= tmo_d;
            addr_q         <= addr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            cnt_q          <= cnt_d;
            hi_q           <= hi_d;
            wr_req_q       <= wr_req_d;
            frame_done_q   <= frame_done_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
`ifdef SERIAL_FB_FILL_EN
            fill_q         <= fill_d;
`endif
        end
    end

    assign wr.wr_req    = wr_req_q;
    assign wr.wr_addr   = wr_addr_q;
    assign wr.wr_data   = wr_data_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_serial_fb_writer.sv
// Randomized self-checking bench for serial_fb_writer: packets are generated from the packet
// rules and expected writes are computed arithmetically; an ack responder plays the arbiter.
module tb_serial_fb_writer;
    localparam int         AW  = 22;
    localparam int         TMO = 100;
    localparam logic [7:0] CMD = 8'hA5;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic [7:0] rx_byte     = 8'h00;
    logic       rbyte_ready = 1'b0;
    logic       busy, frame_done, err_timeout, err_overflow;

    serial_fb_writer_if #(.ADDR_WIDTH(AW)) wr_bus ();

    serial_fb_writer #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .CMD_WRITE(CMD)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rbyte_ready  (rbyte_ready),
        .wr           (wr_bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int to_cnt = 0;
    int stab_err = 0;
    int drop_err = 0;
    int ack_delay = -1;
    bit ack_en = 1'b1;
    bit fill_active = 1'b0;

    logic [AW-1:0] got_addr[$];
    logic [15:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    logic [7:0]    tx_q[$];

    // Arbiter model: acks each request after a delay, records accepted writes, watches stability.
    initial begin : responder
        int            wait_left;
        bit            preq;
        logic [AW-1:0] pa;
        logic [15:0]   pd;
        wr_bus.wr_ack = 1'b0;
        wait_left = -1;
        preq = 1'b0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_cnt++;
            if (err_timeout === 1'b1) to_cnt++;
            if (wr_bus.wr_ack) begin
                wr_bus.wr_ack = 1'b0;
                if (wr_bus.wr_req && !fill_active) drop_err++;
                preq = 1'b0;
                wait_left = -1;
            end else if (wr_bus.wr_req && !reset) begin
                if (preq && (wr_bus.wr_addr !== pa || wr_bus.wr_data !== pd)) stab_err++;
                preq = 1'b1;
                pa = wr_bus.wr_addr;
                pd = wr_bus.wr_data;
                if (wait_left < 0) wait_left = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 4));
                if (ack_en) begin
                    if (wait_left == 0) begin
                        got_addr.push_back(wr_bus.wr_addr);
                        got_data.push_back(wr_bus.wr_data);
                        $display("write addr=%06h data=%04h", wr_bus.wr_addr, wr_bus.wr_data);
                        wr_bus.wr_ack = 1'b1;
                    end else begin
                        wait_left--;
                    end
                end
            end else begin
                preq = 1'b0;
                wait_left = -1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_queues();
        tx_q.delete();
        exp_addr.delete();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic load_bytes(input logic [71:0] pk, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(pk[i*8 +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_byte = b;
        rbyte_ready = 1'b1;
        @(negedge clk);
        rbyte_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_queue();
        foreach (tx_q[i]) send_byte(tx_q[i], int'($urandom_range(8, 12)));
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy && !wr_bus.wr_req) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_bus.wr_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wr_bus.wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got %b exp 0", wr_bus.wr_req); end
        checks++; if (wr_bus.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_bus.wr_addr); end
        checks++; if (wr_bus.wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_bus.wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout got %b exp 0", err_timeout); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err_overflow got %b exp 0", err_overflow); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        bit ok;
        int fd0;
        for (int c = 0; c < 3; c++) begin
            clear_queues();
            case (c)
                0: begin
                    load_bytes(72'hA5_00_01_00_00_12_34, 7);
                    exp_addr.push_back(22'h000100); exp_data.push_back(16'h1234);
                end
                1: begin
                    load_bytes(72'hA5_3F_FF_FF_01_AA_BB_CC_DD, 9);
                    exp_addr.push_back(22'h3FFFFF); exp_data.push_back(16'hAABB);
                    exp_addr.push_back(22'h000000); exp_data.push_back(16'hCCDD);
                end
                default: begin
                    load_bytes(72'h00_FF_A5_00_00_10_00_BE_EF, 9);
                    exp_addr.push_back(22'h000010); exp_data.push_back(16'hBEEF);
                end
            endcase
            ack_delay = (c == 0) ? 3 : -1;
            fd0 = fd_cnt;
            send_queue();
            wait_idle(ok);
            checks++; if (!ok) begin errors++; $display("FAIL directed%0d_idle got busy exp idle", c); end
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL directed%0d_count got %0d exp %0d", c, got_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++;
                    if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                        errors++; $display("FAIL directed%0d_write%0d got %h<=%h exp %h<=%h", c, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL directed%0d_frame_done got %0d exp 1", c, fd_cnt - fd0); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL directed%0d_busy got %b exp 0", c, busy); end
        end
        ack_delay = -1;
    endtask

    task automatic test_random_packets();
        bit          ok;
        int          fd0, nj, len;
        logic [23:0] base;
        logic [15:0] d;
        logic [7:0]  j;
        logic [31:0] s;
        for (int p = 0; p < 12; p++) begin
            clear_queues();
            nj = int'($urandom_range(0, 2));
            for (int k = 0; k < nj; k++) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5 || j == 8'hA6) j = 8'h00;
                tx_q.push_back(j);
            end
            base = 24'($urandom());
            if (p % 3 == 0) base[21:0] = 22'h3FFFFC;
            len = int'($urandom_range(0, 5));
            tx_q.push_back(CMD);
            tx_q.push_back(base[23:16]);
            tx_q.push_back(base[15:8]);
            tx_q.push_back(base[7:0]);
            tx_q.push_back(8'(len));
            for (int i = 0; i <= len; i++) begin
                d = 16'($urandom());
                tx_q.push_back(d[15:8]);
                tx_q.push_back(d[7:0]);
                s = 32'(base) + 32'(i);
                exp_addr.push_back(s[AW-1:0]);
                exp_data.push_back(d);
            end
            fd0 = fd_cnt;
            send_queue();
            wait_idle(ok);
            checks++; if (!ok) begin errors++; $display("FAIL random%0d_idle got busy exp idle", p); end
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL random%0d_count got %0d exp %0d", p, got_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++;
                    if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                        errors++; $display("FAIL random%0d_write%0d got %h<=%h exp %h<=%h", p, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL random%0d_frame_done got %0d exp 1", p, fd_cnt - fd0); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int to0, first_k;
        clear_queues();
        to0 = to_cnt;
        first_k = -1;
        send_byte(8'hA5, 9);
        send_byte(8'h00, 9);
        send_byte(8'h00, 0);
        for (int k = 1; k <= TMO + 20; k++) begin
            @(negedge clk);
            if (err_timeout === 1'b1 && first_k < 0) first_k = k;
        end
        checks++; if (first_k < TMO || first_k > TMO + 1) begin errors++; $display("FAIL timeout_latency got %0d exp %0d..%0d", first_k, TMO, TMO + 1); end
        checks++; if (to_cnt - to0 != 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", to_cnt - to0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
        checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL timeout_no_write got %0d exp 0", got_addr.size()); end
        load_bytes(72'hA5_00_00_07_00_CA_FE, 7);
        send_queue();
        wait_idle(ok);
        checks++;
        if (!ok || got_addr.size() != 1) begin
            errors++; $display("FAIL timeout_recover_count got %0d exp 1", got_addr.size());
        end else begin
            checks++;
            if (got_addr[0] !== 22'h000007 || got_data[0] !== 16'hCAFE) begin
                errors++; $display("FAIL timeout_recover_write got %h<=%h exp 000007<=cafe", got_addr[0], got_data[0]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_queues();
        ack_en = 1'b0;
        load_bytes(72'hA5_00_00_40_01_11_22, 7);
        send_queue();
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL overflow_req got 0 exp 1"); end
        send_byte(8'h33, 2);
        send_byte(8'h44, 2);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b exp 1", err_overflow); end
        ack_en = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h55, 9);
        wait_idle(ok);
        checks++;
        if (got_addr.size() != 2) begin
            errors++; $display("FAIL overflow_count got %0d exp 2", got_addr.size());
        end else begin
            checks++;
            if (got_addr[0] !== 22'h000040 || got_data[0] !== 16'h1122) begin
                errors++; $display("FAIL overflow_write0 got %h<=%h exp 000040<=1122", got_addr[0], got_data[0]);
            end
            checks++;
            if (got_addr[1] !== 22'h000041 || got_data[1] !== 16'h3355) begin
                errors++; $display("FAIL overflow_write1 got %h<=%h exp 000041<=3355", got_addr[1], got_data[1]);
            end
        end
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", err_overflow); end
        pulse_reset();
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL overflow_reset_clear got %b exp 0", err_overflow); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        clear_queues();
        ack_en = 1'b0;
        load_bytes(72'hA5_00_00_50_00_11_22, 7);
        send_queue();
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_req got 0 exp 1"); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (wr_bus.wr_req !== 1'b0) begin errors++; $display("FAIL midreset_drop got %b exp 0", wr_bus.wr_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL midreset_no_write got %0d exp 0", got_addr.size()); end
    endtask

    task automatic test_fill();
        bit ok;
        int fd0, exp_fd;
        clear_queues();
        fill_active = 1'b1;
        load_bytes(72'hA6_00_00_20_03_00_1F, 7);
`ifdef SERIAL_FB_FILL_EN
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(AW'(32'h20 + 32'(i)));
            exp_data.push_back(16'h001F);
        end
        exp_fd = 1;
`else
        exp_fd = 0;
`endif
        fd0 = fd_cnt;
        send_queue();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_idle got busy exp idle"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL fill_count got %0d exp %0d", got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    errors++; $display("FAIL fill_write%0d got %h<=%h exp %h<=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++; if (fd_cnt - fd0 != exp_fd) begin errors++; $display("FAIL fill_frame_done got %0d exp %0d", fd_cnt - fd0, exp_fd); end
        fill_active = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_packets();
        test_timeout();
        test_overflow();
        test_reset_midop();
        test_fill();
        checks++; if (stab_err != 0) begin errors++; $display("FAIL req_stability got %0d exp 0", stab_err); end
        checks++; if (drop_err != 0) begin errors++; $display("FAIL req_drop_after_ack got %0d exp 0", drop_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
